// File: rtl/ahb_lite_master_if.sv
// Bundles the requester command/response handshake and the AHB-Lite
// master-side bus into one connection. The master modport is the initiator's
// view; the slave modport is the requester/slave-model view.
interface ahb_lite_master_if #(
  parameter int ADDR_W = 32
);
  // Requester command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [31:0]       cmd_wdata;

  // Requester response channel
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // AHB-Lite bus
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator. Commands become NONSEQ/SINGLE transfers
// with the address phase of transfer N+1 overlapping the data phase of N.
// Wait states stall both phases; a two-cycle ERROR response cancels (drives
// IDLE for) the pending address phase, which is then reissued unchanged.
// Every completed data phase yields exactly one rsp_valid pulse.
module ahb_lite_master #(
  parameter int         ADDR_W    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_lite_master_if.master bus
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  // Address-phase register
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              write_p0;
  logic [2:0]        size_p0;
  logic [31:0]       wdata_p0;

  // Data-phase register
  logic              vld_p1;
  logic              write_p1;
  logic [31:0]       wdata_p1;

  // Response register
  logic              vld_p2;
  logic [31:0]       rdata_p2;
  logic              err_p2;

  // Set through the second ERROR cycle to suppress the pending address phase
  logic              cncl;

  logic              err_first;
  logic              accept;
  logic              a_done;
  logic              d_done;

  // First ERROR cycle: slave signals ERROR while still holding hready low.
  assign err_first = bus.hresp && !bus.hready;

  // Ready depends only on state and hready/hresp, never on cmd_valid.
  assign bus.cmd_ready = !err_first && !cncl && (!vld_p0 || bus.hready);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign a_done        = vld_p0 && !cncl && bus.hready;
  assign d_done        = vld_p1 && bus.hready;

  assign bus.htrans    = (vld_p0 && !cncl) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr     = addr_p0;
  assign bus.hwrite    = write_p0;
  assign bus.hsize     = size_p0;
  assign bus.hwdata    = wdata_p1;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = HPROT_VAL;
  assign bus.hmastlock = 1'b0;

  assign bus.rsp_valid = vld_p2;
  assign bus.rsp_rdata = rdata_p2;
  assign bus.rsp_err   = err_p2;

  // ---- Stage p0: address phase, loaded on accept, retired on completion
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p0   <= 1'b0;
      addr_p0  <= '0;
      write_p0 <= 1'b0;
      size_p0  <= 3'b000;
      wdata_p0 <= 32'h0;
    end else if (accept) begin
      vld_p0   <= 1'b1;
      addr_p0  <= bus.cmd_addr;
      write_p0 <= bus.cmd_write;
      size_p0  <= bus.cmd_size;
      wdata_p0 <= bus.cmd_wdata;
    end else if (a_done) begin
      vld_p0   <= 1'b0;
    end
  end

  // ---- Stage p1: data phase, fed by a completing address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      wdata_p1 <= 32'h0;
    end else if (a_done) begin
      vld_p1   <= 1'b1;
      write_p1 <= write_p0;
      wdata_p1 <= wdata_p0;
    end else if (d_done) begin
      vld_p1   <= 1'b0;
    end
  end

  // ---- Stage p2: one-cycle response pulse per completed data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p2   <= 1'b0;
      rdata_p2 <= 32'h0;
      err_p2   <= 1'b0;
    end else begin
      vld_p2 <= d_done;
      if (d_done) begin
        err_p2   <= bus.hresp;
        rdata_p2 <= write_p1 ? 32'h0 : bus.hrdata;
      end
    end
  end

  // Cancel flag: raised in the first ERROR cycle, dropped when hready returns
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cncl <= 1'b0;
    end else if (err_first) begin
      cncl <= 1'b1;
    end else if (bus.hready) begin
      cncl <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays requester and AHB slave,
// driving inputs on the falling edge and checking outputs there as well.
module tb_ahb_lite_master;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ahb_lite_master_if #(.ADDR_W(32)) bus ();

  ahb_lite_master #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = 3'd2;
    bus.cmd_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n      = 1'b0;
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_htrans",    32'(bus.htrans),    32'h0);
    chk("rst_haddr",     bus.haddr,          32'h0);
    chk("rst_hwrite",    32'(bus.hwrite),    32'h0);
    chk("rst_hsize",     32'(bus.hsize),     32'h0);
    chk("rst_hwdata",    bus.hwdata,         32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("hburst",        32'(bus.hburst),    32'h0);
    chk("hprot",         32'(bus.hprot),     32'h3);
    chk("hmastlock",     32'(bus.hmastlock), 32'h0);
    rst_n = 1'b1;
    step();

    // Single write, zero wait states
    set_cmd(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    #1 chk("w1_ready", 32'(bus.cmd_ready), 32'h1);
    step();
    bus.cmd_valid = 1'b0;
    chk("w1_htrans", 32'(bus.htrans), 32'h2);
    chk("w1_haddr",  bus.haddr,       32'h10);
    chk("w1_hwrite", 32'(bus.hwrite), 32'h1);
    chk("w1_hsize",  32'(bus.hsize),  32'h2);
    step();
    chk("w1_hwdata",  bus.hwdata,         32'hDEAD_BEEF);
    chk("w1_idle",    32'(bus.htrans),    32'h0);
    chk("w1_rsp_early", 32'(bus.rsp_valid), 32'h0);
    step();
    chk("w1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("w1_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("w1_rsp_rdata", bus.rsp_rdata,      32'h0);
    step();
    chk("w1_rsp_once",  32'(bus.rsp_valid), 32'h0);

    // Read with two wait states
    set_cmd(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    chk("r2_htrans", 32'(bus.htrans), 32'h2);
    chk("r2_haddr",  bus.haddr,       32'h20);
    chk("r2_hwrite", 32'(bus.hwrite), 32'h0);
    step();
    bus.hready = 1'b0;
    chk("r2_dphase_rsp",  32'(bus.rsp_valid), 32'h0);
    chk("r2_dphase_addr", bus.haddr,          32'h20);
    step();
    chk("r2_wait_rsp",    32'(bus.rsp_valid), 32'h0);
    chk("r2_wait_addr",   bus.haddr,          32'h20);
    chk("r2_wait_htrans", 32'(bus.htrans),    32'h0);
    step();
    bus.hready = 1'b1;
    bus.hrdata = 32'h1234_5678;
    chk("r2_wait2_rsp",   32'(bus.rsp_valid), 32'h0);
    chk("r2_wait2_addr",  bus.haddr,          32'h20);
    step();
    bus.hrdata = 32'h0;
    chk("r2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("r2_rsp_rdata", bus.rsp_rdata,      32'h1234_5678);
    chk("r2_rsp_err",   32'(bus.rsp_err),   32'h0);
    step();
    chk("r2_rsp_once",  32'(bus.rsp_valid), 32'h0);

    // Four back-to-back writes
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        set_cmd(1'b1, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i));
        #1 chk("b2b_ready", 32'(bus.cmd_ready), 32'h1);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      step();
      k = i + 1;
      chk("b2b_htrans", 32'(bus.htrans), (k >= 1 && k <= 4) ? 32'h2 : 32'h0);
      if (k <= 4) chk("b2b_haddr", bus.haddr, 32'(4 * (k - 1)));
      if (k >= 2 && k <= 5) chk("b2b_hwdata", bus.hwdata, 32'hA000_0000 + 32'(k - 2));
      chk("b2b_rsp_valid", 32'(bus.rsp_valid), (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
      if (k >= 3 && k <= 6) chk("b2b_rsp_err", 32'(bus.rsp_err), 32'h0);
    end

    // ERROR on write A cancels then reissues read B
    set_cmd(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0055);
    step();
    chk("err_a_htrans", 32'(bus.htrans), 32'h2);
    chk("err_a_haddr",  bus.haddr,       32'h100);
    set_cmd(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    bus.hready    = 1'b0;
    bus.hresp     = 1'b1;
    #1 chk("err_ready_e1", 32'(bus.cmd_ready), 32'h0);
    chk("err_b_htrans", 32'(bus.htrans), 32'h2);
    chk("err_b_haddr",  bus.haddr,       32'h200);
    chk("err_a_hwdata", bus.hwdata,      32'h55);
    step();
    bus.hready = 1'b1;
    chk("err_e2_idle",  32'(bus.htrans),    32'h0);
    chk("err_e2_haddr", bus.haddr,          32'h200);
    chk("err_e2_rsp",   32'(bus.rsp_valid), 32'h0);
    step();
    bus.hresp  = 1'b0;
    bus.hrdata = 32'hCAFE_F00D;
    chk("err_a_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("err_a_rsp_err",   32'(bus.rsp_err),   32'h1);
    chk("err_b_reissue",   32'(bus.htrans),    32'h2);
    chk("err_b_re_haddr",  bus.haddr,          32'h200);
    chk("err_b_re_hwrite", 32'(bus.hwrite),    32'h0);
    step();
    chk("err_b_dphase_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("err_b_dphase_idle", 32'(bus.htrans),   32'h0);
    step();
    bus.hrdata = 32'h0;
    chk("err_b_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("err_b_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("err_b_rsp_rdata", bus.rsp_rdata,      32'hCAFE_F00D);
    step();
    chk("err_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // Reset asserted during a read wait state
    set_cmd(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    chk("rr_htrans", 32'(bus.htrans), 32'h2);
    step();
    bus.hready = 1'b0;
    step();
    chk("rr_wait_rsp", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rr_htrans_idle", 32'(bus.htrans),    32'h0);
    chk("rr_rsp_valid",   32'(bus.rsp_valid), 32'h0);
    chk("rr_haddr",       bus.haddr,          32'h0);
    bus.hready = 1'b1;
    step();
    rst_n = 1'b1;
    #1 chk("rr_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end

    // Command held across a stalled data phase
    set_cmd(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0011);
    step();
    set_cmd(1'b1, 1'b1, 32'h0000_0404, 32'h0000_0022);
    #1 chk("st_ready_c1", 32'(bus.cmd_ready), 32'h1);
    step();
    set_cmd(1'b1, 1'b1, 32'h0000_0408, 32'h0000_0033);
    bus.hready = 1'b0;
    #1 chk("st_ready_stall", 32'(bus.cmd_ready), 32'h0);
    chk("st_c1_haddr", bus.haddr, 32'h404);
    for (int i = 0; i < 2; i++) begin
      step();
      if (i == 1) bus.hready = 1'b1;
      #1 chk("st_ready_hold", 32'(bus.cmd_ready), (i == 1) ? 32'h1 : 32'h0);
      chk("st_htrans", 32'(bus.htrans),    32'h2);
      chk("st_haddr",  bus.haddr,          32'h404);
      chk("st_hwdata", bus.hwdata,         32'h11);
      chk("st_rsp",    32'(bus.rsp_valid), 32'h0);
    end
    step();
    bus.cmd_valid = 1'b0;
    chk("st_c0_rsp",   32'(bus.rsp_valid), 32'h1);
    chk("st_c2_haddr", bus.haddr,          32'h408);
    chk("st_c2_htrans", 32'(bus.htrans),   32'h2);
    chk("st_c1_hwdata", bus.hwdata,        32'h22);
    step();
    chk("st_c1_rsp",    32'(bus.rsp_valid), 32'h1);
    chk("st_c2_hwdata", bus.hwdata,         32'h33);
    chk("st_idle",      32'(bus.htrans),    32'h0);
    step();
    chk("st_c2_rsp",    32'(bus.rsp_valid), 32'h1);
    step();
    chk("st_no_dup",    32'(bus.rsp_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite bus initiator that turns single-transfer commands from a local requester (test sequencer, DMA or CPU-side shim) into pipelined NONSEQ/SINGLE transfers toward AHB slaves such as the on-chip RAM. It overlaps address and data phases, honours slave wait states, and handles two-cycle ERROR responses. Each completed transfer returns exactly one response: read data for reads, plus an error flag for every transfer.

## Interface
- ADDR_W, 32, address width.
- HPROT_VAL, 4'b0011, constant driven on hprot (non-cacheable, privileged, data).
- HCLK  in  1  bus clock; all flops rise-edge.
- HRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  3  hsize encoding; only 0, 1 and 2 are legal.
- cmd_wdata  in  32  write data, captured at accept.
- rsp_valid  out  1  one-cycle pulse per completed transfer; no backpressure.
- rsp_rdata  out  32  hrdata sampled at completion. Valid for reads; 0 for writes.
- rsp_err  out  1  hresp sampled at completion.
- haddr  out  ADDR_W  address phase.
- htrans  out  2  IDLE = 2'b00, NONSEQ = 2'b10 only.
- hwrite  out  1
- hsize  out  3
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant HPROT_VAL.
- hmastlock  out  1  constant 0.
- hwdata  out  32  data phase.
- hrdata  in  32
- hready  in  1  transfer-done / bus-ready from the interconnect.
- hresp  in  1  0 = OKAY, 1 = ERROR.

## Operation
- State:
  - Address-phase register: a_vld, addr, write, size, wdata.
  - Data-phase register: d_vld, d_write, d_wdata.
  - Cancel flag: cncl.
- cmd_ready = !(hresp && !hready) && !cncl && (!a_vld || hready). This is combinational on hready/hresp; no dependency back onto cmd_valid.
- Accept: load the address-phase register, set a_vld.
- Bus outputs:
  - htrans = NONSEQ when a_vld && !cncl, else IDLE.
  - haddr, hwrite and hsize come from the address-phase register and hold their last value when idle.
- Address-phase completion (edge with hready=1, htrans=NONSEQ):
  - Copy into the data-phase register, set d_vld.
  - Clear a_vld unless a new command is accepted on the same edge.
- hwdata = d_wdata throughout the data phase; it holds its last value otherwise.
- Data-phase completion (edge with d_vld && hready):
  - Next cycle: rsp_valid=1, rsp_err=hresp, rsp_rdata = d_write ? 0 : hrdata.
  - Clear d_vld unless a new address phase completes on the same edge.
- ERROR handling:
  - On an edge with hresp=1 && hready=0 (first ERROR cycle), set cncl.
  - The pending address phase, if any, is driven as IDLE during the second ERROR cycle; the command is retained.
  - cncl clears on the next edge with hready=1. The retained command is then reissued as NONSEQ with unchanged addr/size/write/wdata.
  - Commands are never dropped.
- Illegal cmd_size (3..7) is passed through unchecked; the slave is responsible for responding with ERROR.
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, a_vld=d_vld=cncl=0, which gives cmd_ready=1.
- Reset mid-transfer: all state clears immediately and asynchronously. In-flight transfers produce no response.

## Timing
- Accept at edge E0:
  - NONSEQ is driven in cycle E0–E1.
  - With zero wait states, the data phase runs E1–E2 and rsp_valid is high E2–E3.
  - Latency: 3 cycles from accept to response pulse.
- Throughput: one transfer per cycle with back-to-back cmd_valid and hready=1. Address phase N+1 overlaps data phase N.
- Each wait state (hready=0) stalls both the address and data registers by one cycle. htrans/haddr/hwdata stay stable.
- Responses return in command order, one per issued NONSEQ.

## Test plan
- Write to 0x0000_0010, size 2, wdata 0xDEADBEEF, hready=1 -> NONSEQ/hwrite=1 in the cycle after accept; hwdata=0xDEADBEEF the next cycle; rsp_valid with rsp_err=0 three cycles after accept.
- Read from 0x0000_0020, slave inserts 2 wait states, hrdata=0x12345678 -> hwdata/haddr stable during waits; rsp_rdata=0x12345678 exactly once, 5 cycles after accept.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC with hready=1 -> htrans NONSEQ for 4 consecutive cycles; 4 consecutive rsp_valid pulses in order, all rsp_err=0.
- Write to A, then read from B accepted; slave returns ERROR for A -> htrans=IDLE in the second ERROR cycle; read B reissued the cycle after; responses are A with rsp_err=1, then B with rsp_err=0.
- Assert HRESETn=0 mid-read during a wait state -> htrans=IDLE and rsp_valid=0 immediately; cmd_ready=1 after release; no response for the aborted read.
- cmd_valid held during a hready=0 data phase with a_vld=1 -> cmd_ready=0 until hready=1; new command captured on that edge with no loss or duplication.
